vga_sync_decoder: RTL

//  Receive end of the 640x480@60 VGA timing interface. Takes active-low h_sync/v_sync from a

---
 rtl/vga_sync_decoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Receive side of a VGA timing link: resynchronises h/v sync, locks a local pixel/line
// counter pair to the sync edges and reports lock status and timing errors.
module vga_sync_decoder #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FPORCH    = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BPORCH    = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FPORCH    = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BPORCH    = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       inclk,
  input  logic       reset_n,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_LAST    = 10'(H_DISPLAY + H_FPORCH + H_SYNC + H_BPORCH - 1);
  localparam logic [9:0] V_LAST    = 10'(V_DISPLAY + V_FPORCH + V_SYNC + V_BPORCH - 1);
  localparam logic [9:0] H_FALL_AT = 10'(H_DISPLAY + H_FPORCH);
  localparam logic [9:0] H_RISE_AT = 10'(H_DISPLAY + H_FPORCH + H_SYNC);
  localparam logic [9:0] V_FALL_AT = 10'(V_DISPLAY + V_FPORCH);
  localparam logic [9:0] H_VIS     = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS     = 10'(V_DISPLAY);
  localparam logic [3:0] LOCK_N    = 4'(LOCK_FRAMES);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_H_ALIGN = 2'd1;
  localparam logic [1:0] ST_VERIFY  = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  logic [2:0] hs_q;
  logic [2:0] vs_q;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic [1:0] state_q, state_d;
  logic [3:0] good_q, good_d;
  logic       locked_q;
  logic       sync_err_q;
  logic [7:0] err_count_q;

  logic       h_fall, h_rise, v_fall;
  logic       h_wrap, h_bad, v_bad, err_hit;
  logic [9:0] h_exp, v_exp;
  logic [3:0] good_inc;

  // Bits [1:0] form the two-flop synchroniser; bit 2 is the previous value for edge detect.
  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 3'b111;
      vs_q <= 3'b111;
    end else begin
      hs_q <= {hs_q[1:0], h_sync_in};
      vs_q <= {vs_q[1:0], v_sync_in};
    end
  end

  assign h_fall = hs_q[2] & ~hs_q[1];
  assign h_rise = ~hs_q[2] & hs_q[1];
  assign v_fall = vs_q[2] & ~vs_q[1];

  always_comb begin
    h_wrap = (pos_x_q == H_LAST);
    h_exp  = h_wrap ? 10'd0 : pos_x_q + 10'd1;
    if (h_wrap) begin
      v_exp = (pos_y_q == V_LAST) ? 10'd0 : pos_y_q + 10'd1;
    end else begin
      v_exp = pos_y_q;
    end
    // A line that reaches the fall position without an h_fall counts as a bad h edge.
    h_bad = (h_fall && (h_exp != H_FALL_AT)) ||
            (h_rise && (h_exp != H_RISE_AT)) ||
            (!h_fall && (h_exp == H_FALL_AT));
    v_bad = v_fall && ((v_exp != V_FALL_AT) || (h_exp != 10'd0));
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    err_hit  = 1'b0;
    good_inc = good_q + 4'd1;
    // A good edge lands on the load value anyway, so every edge may reload unconditionally.
    pos_x_d  = h_fall ? H_FALL_AT : h_exp;
    pos_y_d  = (v_fall && (state_q != ST_SEARCH)) ? V_FALL_AT : v_exp;
    case (state_q)
      ST_SEARCH: begin
        if (h_fall) state_d = ST_H_ALIGN;
        else        state_d = ST_SEARCH;
      end
      ST_H_ALIGN: begin
        if (v_fall && !h_bad) begin
          good_d  = 4'd0;
          state_d = ST_VERIFY;
        end else begin
          state_d = ST_H_ALIGN;
        end
      end
      ST_VERIFY: begin
        if (h_bad || v_bad) begin
          good_d  = 4'd0;
          state_d = ST_H_ALIGN;
        end else if (v_fall) begin
          good_d = good_inc;
          if (good_inc == LOCK_N) state_d = ST_LOCKED;
          else                    state_d = ST_VERIFY;
        end else begin
          state_d = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (h_bad || v_bad) begin
          err_hit = 1'b1;
          good_d  = 4'd0;
          state_d = h_bad ? ST_H_ALIGN : ST_VERIFY;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Counters, FSM and registered status outputs.
  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q     <= 10'd0;
      pos_y_q     <= 10'd0;
      state_q     <= ST_SEARCH;
      good_q      <= 4'd0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      state_q    <= state_d;
      good_q     <= good_d;
      locked_q   <= (state_d == ST_LOCKED);
      sync_err_q <= err_hit;
      if (err_hit && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end else begin
        err_count_q <= err_count_q;
      end
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign err_count   = err_count_q;
  assign video_on    = locked_q && (pos_x_q < H_VIS) && (pos_y_q < V_VIS);
  assign frame_start = locked_q && (pos_x_q == 10'd0) && (pos_y_q == 10'd0);

endmodule
